// File: rtl/uart_rx_frame_receiver_if.sv
// Receive-side bundle of the UART: serial line and frame configuration in,
// received word and one-cycle status strobes out.
interface uart_rx_frame_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    // Line and configuration source (transmitter side / bench)
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    // The receiver itself
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_frame_receiver.sv
// Oversampling UART frame receiver: start detect, LSB-first data, optional parity, stop check.
// Optional 2-of-3 majority sampling of every bit is enabled by defining UART_RX_MAJORITY_VOTE_EN.
module uart_rx_frame_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input logic                    CLK,
    input logic                    RST,
    uart_rx_frame_receiver_if.slave rx_if
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Unsupported oversampling ratios fall back to 8 so the frame still completes.
    function automatic logic [5:0] legal_pre(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            6'd8, 6'd16, 6'd32: r = p;
            default:            r = 6'd8;
        endcase
        return r;
    endfunction

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

`ifdef UART_RX_MAJORITY_VOTE_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_t                  state_q,      state_d;
    logic [5:0]              edge_cnt_q,   edge_cnt_d;
    logic [BCW-1:0]          bit_cnt_q,    bit_cnt_d;
    logic [5:0]              pre_q,        pre_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic                    bad_start_q,  bad_start_d;
    logic                    par_fail_q,   par_fail_d;
    logic                    stp_fail_q,   stp_fail_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]              vote_q,       vote_d;
`endif

    logic [5:0] half_s;
    logic [5:0] edge_next_s;
    logic       at_last_s;
    logic       sample_now_s;
    logic       sample_bit_s;

    // Bit timing: end-of-bit detection and the point where the bit value is decided
    always_comb begin
        half_s      = {1'b0, pre_q[5:1]};
        at_last_s   = (edge_cnt_q == (pre_q - 6'd1));
        edge_next_s = at_last_s ? 6'd0 : (edge_cnt_q + 6'd1);
`ifdef UART_RX_MAJORITY_VOTE_EN
        // vote_q holds the line at Pre/2-1 and Pre/2 when the third sample arrives
        vote_d       = {vote_q[0], rx_if.RX_IN};
        sample_now_s = (edge_cnt_q == (half_s + 6'd1));
        sample_bit_s = majority3(vote_q[1], vote_q[0], rx_if.RX_IN);
`else
        sample_now_s = (edge_cnt_q == half_s);
        sample_bit_s = rx_if.RX_IN;
`endif
    end

    // Next-state, datapath and strobe computation for the frame FSM
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        bad_start_d  = bad_start_q;
        par_fail_d   = par_fail_q;
        stp_fail_d   = stp_fail_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = {BCW{1'b0}};
                if (!rx_if.RX_IN) begin
                    // This cycle is edge 0 of the start bit; configuration is frozen here.
                    state_d     = S_START;
                    edge_cnt_d  = 6'd1;
                    pre_d       = legal_pre(rx_if.Prescale);
                    par_en_d    = rx_if.PAR_EN;
                    par_typ_d   = rx_if.PAR_TYP;
                    shift_d     = {DATA_WIDTH{1'b0}};
                    bad_start_d = 1'b0;
                    par_fail_d  = 1'b0;
                    stp_fail_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                edge_cnt_d = edge_next_s;
                if (sample_now_s && sample_bit_s) begin
                    bad_start_d = 1'b1;
                end else begin
                    bad_start_d = bad_start_q;
                end
                if (at_last_s) begin
                    state_d = bad_start_q ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end

            S_DATA: begin
                edge_cnt_d = edge_next_s;
                if (sample_now_s) begin
                    shift_d[bit_cnt_q] = sample_bit_s;
                end else begin
                    shift_d = shift_q;
                end
                if (at_last_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = {BCW{1'b0}};
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        state_d   = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end

            S_PARITY: begin
                edge_cnt_d = edge_next_s;
                if (sample_now_s && (sample_bit_s != parity_bit(shift_q, par_typ_q))) begin
                    par_fail_d = 1'b1;
                end else begin
                    par_fail_d = par_fail_q;
                end
                if (at_last_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end

            S_STOP: begin
                edge_cnt_d = edge_next_s;
                if (sample_now_s && !sample_bit_s) begin
                    stp_fail_d = 1'b1;
                end else begin
                    stp_fail_d = stp_fail_q;
                end
                // Strobes are loaded on the way into DONE so they are visible during DONE.
                if (at_last_s) begin
                    state_d   = S_DONE;
                    par_err_d = par_fail_q;
                    stp_err_d = stp_fail_q;
                    if (!par_fail_q && !stp_fail_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end else begin
                        data_valid_d = 1'b0;
                        p_data_d     = p_data_q;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                edge_cnt_d = 6'd0;
            end

            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = {BCW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= {BCW{1'b0}};
            pre_q        <= 6'd8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= {DATA_WIDTH{1'b0}};
            bad_start_q  <= 1'b0;
            par_fail_q   <= 1'b0;
            stp_fail_q   <= 1'b0;
            p_data_q     <= {DATA_WIDTH{1'b0}};
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q       <= 2'b11;
`endif
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            bad_start_q  <= bad_start_d;
            par_fail_q   <= par_fail_d;
            stp_fail_q   <= stp_fail_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q       <= vote_d;
`endif
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.par_err    = par_err_q;
    assign rx_if.stp_err    = stp_err_q;

endmodule
